fp_stream_scoreboard: RTL and testbench
=======================================

# fp_stream_scoreboard

Synthesizable, parametrised result checker for floating-point datapath units such as the FP16 FMA. Expected results are pushed into an internal FIFO when operands are launched. DUT results are popped and compared lane by lane when they emerge. The comparison is IEEE-aware: zeros, NaNs and an ULP tolerance are all handled. The block sits beside the DUT in simulation and FPGA self-test harnesses, and reports mismatches, counts and sticky FIFO faults.

## Interface
Parameters:
- EXP_BITS, 5, exponent width
- MAN_BITS, 10, mantissa width; WIDTH = EXP_BITS+MAN_BITS+1
- LANES, 1, parallel result lanes per transaction
- DEPTH, 16, expected-FIFO entries (power of 2, ≥2)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- clear  in  1  synchronous: empty FIFO, zero counters and stickies
- ulp_tol  in  8  allowed magnitude distance in ULPs; quasi-static
- exp_valid  in  1  push expected transaction
- exp_data  in  LANES*WIDTH  expected values, lane 0 in LSBs
- exp_ready  out  1  FIFO not full
- dut_valid  in  1  DUT result transaction present
- dut_data  in  LANES*WIDTH  DUT values
- err_pulse  out  1  one-cycle pulse on mismatch
- err_lane_mask  out  LANES  mismatching lanes of last compare; held until next compare
- cmp_count  out  32  compares performed, saturating
- err_count  out  32  mismatching transactions, saturating
- first_err_idx  out  32  cmp_count value of first mismatch; valid when any_err
- any_err  out  1  sticky
- overflow  out  1  sticky: push while full (without simultaneous pop)
- underflow  out  1  sticky: dut_valid while FIFO empty
- pending  out  $clog2(DEPTH+1)  FIFO occupancy

## Operation
- FIFO: circular, separate read/write pointers plus occupancy counter.
- Push when exp_valid && (!full || pop this cycle). Push while full with no pop sets overflow; that data is dropped.
- Pop when dut_valid && !empty.
- dut_valid while empty sets underflow. No compare occurs and the DUT data is discarded.
- No bypass: a push in the same cycle as dut_valid on an empty FIFO does not satisfy that dut_valid.
- Simultaneous push and pop while full: both occur, occupancy unchanged, no overflow.
- Per-lane equality rules, applied in order:
  - both NaN (exp all ones, mantissa ≠0): equal, regardless of sign or payload
  - exactly one NaN: mismatch
  - both ±0 (bits[WIDTH-2:0]==0): equal, regardless of sign
  - signs differ: mismatch
  - otherwise: distance = |E[WIDTH-2:0] − A[WIDTH-2:0]|, computed WIDTH bits wide. Mismatch iff distance > ulp_tol.
  - Consequence: Inf vs largest finite of the same sign has distance 1.
- Transaction mismatch = OR of lane mismatches.
- Counters:
  - cmp_count increments on every compare.
  - err_count increments on every mismatching transaction.
  - Both saturate at 0xFFFF_FFFF.
  - On the first mismatch, first_err_idx latches the pre-increment cmp_count and any_err sets.
- clear has priority over push, pop and compare in its cycle.

## Timing
- Reset values: exp_ready=1, pending=0, all other outputs 0.
- Reset mid-operation asynchronously discards FIFO contents and in-flight compares.
- Two-stage pipeline:
  - dut_valid at edge N: pop; expected/actual pair registered.
  - Edge N+1: per-lane classification and distance registered.
  - Edge N+2: err_pulse, err_lane_mask, counters, any_err and first_err_idx updated.
- Throughput: one compare per cycle.
- exp_ready and pending reflect the state after the current edge (registered, not combinational from the inputs).
- underflow and overflow are set at the edge where the fault occurs.
- clear also kills in-flight pipeline stages.

## Structure
- Package fp_chk_pkg holds:
  - WIDTH derivation
  - fp_class_e typedef (ZERO, NAN, INF, FINITE)
  - fp_classify() function
  - ulp_distance() function
- Sub-module fp_chk_fifo: parametrised circular FIFO with full/empty/occupancy.
- Top level holds the compare pipeline and counters.

## Test plan
- Defaults, ulp_tol=0. Push 3c00, 4000, c200, 7c00; DUT returns the same four → cmp_count=4, err_count=0, any_err=0, pending=0.
- Push 7e00 / 0000. DUT returns fe01 / 8000 → both equal, no err_pulse.
- Push 3c00. DUT returns 3c01:
  - ulp_tol=0 → err_pulse two cycles after dut_valid, err_lane_mask=1, first_err_idx=0
  - repeat with ulp_tol=1 → no error
- DEPTH=4. Five pushes with no pops → overflow=1, pending=4, exp_ready=0. Then push and pop in the same cycle → pending stays 4, overflow unchanged.
- dut_valid with empty FIFO, same cycle as exp_valid → underflow=1, cmp_count=0, pending=1.
- LANES=4. Push 4 lanes, DUT corrupts lane 2 → err_lane_mask=4'b0100, err_count=1. Assert reset mid-stream → every output returns to its reset value immediately.

Source files
------------

// File: rtl/fp_chk_pkg.sv
// Shared types and helpers for the floating-point stream scoreboard:
// format width derivation, operand classification and magnitude distance.
package fp_chk_pkg;

    localparam int FP_MAX_W = 64;

    typedef enum logic [1:0] {ZERO, NAN, INF, FINITE} fp_class_e;

    function automatic int fp_width(input int exp_bits, input int man_bits);
        return exp_bits + man_bits + 1;
    endfunction

    function automatic fp_class_e fp_classify(input logic [FP_MAX_W-1:0] v,
                                              input int exp_bits,
                                              input int man_bits);
        logic [FP_MAX_W-1:0] exp_mask;
        logic [FP_MAX_W-1:0] man_mask;
        logic [FP_MAX_W-1:0] mag_mask;
        logic [FP_MAX_W-1:0] exp_f;
        logic [FP_MAX_W-1:0] man_f;
        man_mask = (64'd1 << man_bits) - 64'd1;
        exp_mask = (64'd1 << exp_bits) - 64'd1;
        mag_mask = (64'd1 << (exp_bits + man_bits)) - 64'd1;
        exp_f    = (v >> man_bits) & exp_mask;
        man_f    = v & man_mask;
        if (exp_f == exp_mask && man_f != '0)
            return NAN;
        if (exp_f == exp_mask)
            return INF;
        if ((v & mag_mask) == '0)
            return ZERO;
        return FINITE;
    endfunction

    // Sign-magnitude encodings are monotonic in magnitude, so the ULP distance
    // is the plain difference of the magnitude fields.
    function automatic logic [FP_MAX_W-1:0] ulp_distance(input logic [FP_MAX_W-1:0] e,
                                                         input logic [FP_MAX_W-1:0] a,
                                                         input int width);
        logic [FP_MAX_W-1:0] mag_mask;
        logic [FP_MAX_W-1:0] me;
        logic [FP_MAX_W-1:0] ma;
        mag_mask = (64'd1 << (width - 1)) - 64'd1;
        me = e & mag_mask;
        ma = a & mag_mask;
        return (me >= ma) ? (me - ma) : (ma - me);
    endfunction

endpackage

// File: rtl/fp_chk_fifo.sv
// Circular FIFO of expected transactions with occupancy counter and a
// registered read port (read-before-write when push and pop share a slot).
module fp_chk_fifo #(
    parameter  int DW    = 16,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [DW-1:0] rd_data_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop)
                count_reg <= count_reg + 1'b1;
            else if (pop && !push)
                count_reg <= count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= wr_data;
        if (pop)
            rd_data_reg <= mem[rd_ptr_reg];
    end

    assign rd_data = rd_data_reg;
    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;

endmodule

// File: rtl/fp_stream_scoreboard.sv
// Result checker: expected values queue in a FIFO, DUT results are compared
// lane by lane (NaN/zero aware, ULP tolerant) through a two-stage pipeline.
module fp_stream_scoreboard
    import fp_chk_pkg::*;
#(
    parameter  int EXP_BITS = 5,
    parameter  int MAN_BITS = 10,
    parameter  int LANES    = 1,
    parameter  int DEPTH    = 16,
    localparam int WIDTH    = fp_width(EXP_BITS, MAN_BITS),
    localparam int PW       = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic [7:0]             ulp_tol,
    input  logic                   exp_valid,
    input  logic [LANES*WIDTH-1:0] exp_data,
    output logic                   exp_ready,
    input  logic                   dut_valid,
    input  logic [LANES*WIDTH-1:0] dut_data,
    output logic                   err_pulse,
    output logic [LANES-1:0]       err_lane_mask,
    output logic [31:0]            cmp_count,
    output logic [31:0]            err_count,
    output logic [31:0]            first_err_idx,
    output logic                   any_err,
    output logic                   overflow,
    output logic                   underflow,
    output logic [PW-1:0]          pending
);

    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push;
    logic                   pop;
    logic [LANES*WIDTH-1:0] fifo_rd_data;
    logic [PW-1:0]          fifo_count;

    logic                   s1_valid_reg;
    logic [LANES*WIDTH-1:0] s1_act_reg;
    logic                   s2_valid_reg;
    logic [LANES-1:0]       lane_mismatch;

    logic                   err_pulse_reg;
    logic [LANES-1:0]       err_lane_mask_reg;
    logic [31:0]            cmp_count_reg;
    logic [31:0]            err_count_reg;
    logic [31:0]            first_err_idx_reg;
    logic                   any_err_reg;
    logic                   overflow_reg;
    logic                   underflow_reg;

    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // accepted when paired with a pop.
    assign pop  = dut_valid && !fifo_empty && !clear;
    assign push = exp_valid && (!fifo_full || pop) && !clear;

    fp_chk_fifo #(
        .DW    (LANES*WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .push    (push),
        .pop     (pop),
        .wr_data (exp_data),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Stage 1: the FIFO's registered read and the DUT data land together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_reg  <= 1'b0;
            s1_act_reg    <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (clear) begin
            s1_valid_reg  <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            s1_valid_reg <= pop;
            if (pop)
                s1_act_reg <= dut_data;
            if (exp_valid && fifo_full && !pop)
                overflow_reg <= 1'b1;
            if (dut_valid && fifo_empty)
                underflow_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            s2_valid_reg <= 1'b0;
        else if (clear)
            s2_valid_reg <= 1'b0;
        else
            s2_valid_reg <= s1_valid_reg;
    end

    // Stage 2: per-lane classification and distance.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [WIDTH-1:0] lane_e;
        logic [WIDTH-1:0] lane_a;
        fp_class_e        cls_e_reg;
        fp_class_e        cls_a_reg;
        logic             sign_diff_reg;
        logic [WIDTH-1:0] dist_reg;

        assign lane_e = fifo_rd_data[gi*WIDTH +: WIDTH];
        assign lane_a = s1_act_reg[gi*WIDTH +: WIDTH];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cls_e_reg     <= ZERO;
                cls_a_reg     <= ZERO;
                sign_diff_reg <= 1'b0;
                dist_reg      <= '0;
            end else if (s1_valid_reg) begin
                cls_e_reg     <= fp_classify(FP_MAX_W'(lane_e), EXP_BITS, MAN_BITS);
                cls_a_reg     <= fp_classify(FP_MAX_W'(lane_a), EXP_BITS, MAN_BITS);
                sign_diff_reg <= lane_e[WIDTH-1] ^ lane_a[WIDTH-1];
                dist_reg      <= WIDTH'(ulp_distance(FP_MAX_W'(lane_e), FP_MAX_W'(lane_a), WIDTH));
            end
        end

        // Rule order matters: NaN handling, then signed zeros, then sign, then distance.
        assign lane_mismatch[gi] =
            (cls_e_reg == NAN && cls_a_reg == NAN)   ? 1'b0 :
            (cls_e_reg == NAN || cls_a_reg == NAN)   ? 1'b1 :
            (cls_e_reg == ZERO && cls_a_reg == ZERO) ? 1'b0 :
            sign_diff_reg                            ? 1'b1 :
            (FP_MAX_W'(dist_reg) > FP_MAX_W'(ulp_tol));
    end

    // Stage 3: verdict, counters and stickies.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_pulse_reg     <= 1'b0;
            err_lane_mask_reg <= '0;
            cmp_count_reg     <= '0;
            err_count_reg     <= '0;
            first_err_idx_reg <= '0;
            any_err_reg       <= 1'b0;
        end else if (clear) begin
            err_pulse_reg     <= 1'b0;
            err_lane_mask_reg <= '0;
            cmp_count_reg     <= '0;
            err_count_reg     <= '0;
            first_err_idx_reg <= '0;
            any_err_reg       <= 1'b0;
        end else begin
            err_pulse_reg <= 1'b0;
            if (s2_valid_reg) begin
                err_lane_mask_reg <= lane_mismatch;
                err_pulse_reg     <= |lane_mismatch;
                if (cmp_count_reg != '1)
                    cmp_count_reg <= cmp_count_reg + 32'd1;
                if (|lane_mismatch) begin
                    if (err_count_reg != '1)
                        err_count_reg <= err_count_reg + 32'd1;
                    if (!any_err_reg) begin
                        first_err_idx_reg <= cmp_count_reg;
                        any_err_reg       <= 1'b1;
                    end
                end
            end
        end
    end

    assign exp_ready     = !fifo_full;
    assign pending       = fifo_count;
    assign err_pulse     = err_pulse_reg;
    assign err_lane_mask = err_lane_mask_reg;
    assign cmp_count     = cmp_count_reg;
    assign err_count     = err_count_reg;
    assign first_err_idx = first_err_idx_reg;
    assign any_err       = any_err_reg;
    assign overflow      = overflow_reg;
    assign underflow     = underflow_reg;

endmodule

// File: tb/tb_fp_stream_scoreboard.sv
// Self-checking bench: directed scenarios plus randomized traffic, all outputs
// compared every cycle against a queue-based reference model.
module tb_fp_stream_scoreboard;

    localparam int EXP_BITS = 5;
    localparam int MAN_BITS = 10;
    localparam int LANES    = 4;
    localparam int DEPTH    = 4;
    localparam int W        = 16;
    localparam int DW       = LANES * W;
    localparam int PW       = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          clear;
    logic [7:0]    ulp_tol;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    logic          exp_ready;
    logic          dut_valid;
    logic [DW-1:0] dut_data;
    logic          err_pulse;
    logic [LANES-1:0] err_lane_mask;
    logic [31:0]   cmp_count;
    logic [31:0]   err_count;
    logic [31:0]   first_err_idx;
    logic          any_err;
    logic          overflow;
    logic          underflow;
    logic [PW-1:0] pending;

    fp_stream_scoreboard #(
        .EXP_BITS (EXP_BITS),
        .MAN_BITS (MAN_BITS),
        .LANES    (LANES),
        .DEPTH    (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .clear         (clear),
        .ulp_tol       (ulp_tol),
        .exp_valid     (exp_valid),
        .exp_data      (exp_data),
        .exp_ready     (exp_ready),
        .dut_valid     (dut_valid),
        .dut_data      (dut_data),
        .err_pulse     (err_pulse),
        .err_lane_mask (err_lane_mask),
        .cmp_count     (cmp_count),
        .err_count     (err_count),
        .first_err_idx (first_err_idx),
        .any_err       (any_err),
        .overflow      (overflow),
        .underflow     (underflow),
        .pending       (pending)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit saw_pulse;

    // Reference model state
    logic [DW-1:0]    mq[$];
    logic [31:0]      m_cmp, m_err, m_first;
    bit               m_any, m_ovf, m_unf, m_pulse;
    logic [LANES-1:0] m_mask;
    bit               d1_v, d2_v;
    logic [LANES-1:0] d1_m, d2_m;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit lane_bad(input int e, input int a, input int tol);
        int  me, ma, d;
        bit  ne, na;
        me = e & 'h7fff;
        ma = a & 'h7fff;
        ne = ((me >> 10) == 31) && ((me & 'h3ff) != 0);
        na = ((ma >> 10) == 31) && ((ma & 'h3ff) != 0);
        if (ne && na) return 1'b0;
        if (ne || na) return 1'b1;
        if (me == 0 && ma == 0) return 1'b0;
        if (((e >> 15) & 1) != ((a >> 15) & 1)) return 1'b1;
        d = me - ma;
        if (d < 0) d = -d;
        return d > tol;
    endfunction

    function automatic logic [LANES-1:0] mask_of(input logic [DW-1:0] e, input logic [DW-1:0] a);
        logic [LANES-1:0] m;
        m = '0;
        for (int i = 0; i < LANES; i++)
            m[i] = lane_bad(int'(e[i*W +: W]), int'(a[i*W +: W]), int'(ulp_tol));
        return m;
    endfunction

    function automatic logic [DW-1:0] rep4(input logic [15:0] v);
        return {v, v, v, v};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_cmp = 0; m_err = 0; m_first = 0;
        m_any = 0; m_ovf = 0; m_unf = 0; m_pulse = 0; m_mask = '0;
        d1_v = 0; d2_v = 0; d1_m = '0; d2_m = '0;
    endtask

    task automatic model_edge(input bit ev, input logic [DW-1:0] ed,
                              input bit dv, input logic [DW-1:0] dd, input bit clr);
        int sz;
        bit popped;
        if (clr) begin
            model_reset();
            return;
        end
        m_pulse = 0;
        if (d2_v) begin
            m_mask  = d2_m;
            m_pulse = (d2_m != '0);
            if (d2_m != '0 && !m_any) begin
                m_first = m_cmp;
                m_any   = 1;
            end
            if (d2_m != '0 && m_err != 32'hFFFF_FFFF) m_err++;
            if (m_cmp != 32'hFFFF_FFFF) m_cmp++;
            $display("txn cmp=%0d mask=%b pulse=%0d", m_cmp, m_mask, m_pulse);
        end
        d2_v = d1_v; d2_m = d1_m;
        d1_v = 0;    d1_m = '0;
        sz = mq.size();
        popped = 0;
        if (dv) begin
            if (sz > 0) begin
                d1_v = 1;
                d1_m = mask_of(mq[0], dd);
                void'(mq.pop_front());
                popped = 1;
            end else begin
                m_unf = 1;
            end
        end
        if (ev) begin
            if (sz < DEPTH || popped) mq.push_back(ed);
            else m_ovf = 1;
        end
    endtask

    task automatic check_all();
        chk("exp_ready", exp_ready, (mq.size() < DEPTH));
        chk("pending", pending, mq.size());
        chk("err_pulse", err_pulse, m_pulse);
        chk("err_lane_mask", err_lane_mask, m_mask);
        chk("cmp_count", cmp_count, m_cmp);
        chk("err_count", err_count, m_err);
        chk("first_err_idx", first_err_idx, m_first);
        chk("any_err", any_err, m_any);
        chk("overflow", overflow, m_ovf);
        chk("underflow", underflow, m_unf);
    endtask

    task automatic cycle(input bit ev, input logic [DW-1:0] ed,
                         input bit dv, input logic [DW-1:0] dd, input bit clr);
        exp_valid = ev; exp_data = ed;
        dut_valid = dv; dut_data = dd;
        clear = clr;
        @(posedge clk);
        model_edge(ev, ed, dv, dd, clr);
        #1;
        if (err_pulse) saw_pulse = 1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, '0, 0, '0, 0);
    endtask

    task automatic do_clear();
        cycle(0, '0, 0, '0, 1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_exp_ready"}, exp_ready, 1);
        chk({tag, "_pending"}, pending, 0);
        chk({tag, "_err_pulse"}, err_pulse, 0);
        chk({tag, "_mask"}, err_lane_mask, 0);
        chk({tag, "_cmp"}, cmp_count, 0);
        chk({tag, "_err"}, err_count, 0);
        chk({tag, "_first"}, first_err_idx, 0);
        chk({tag, "_any"}, any_err, 0);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_unf"}, underflow, 0);
    endtask

    function automatic logic [15:0] gen_val();
        logic [15:0] s;
        s = 16'($urandom_range(0, 1)) << 15;
        case ($urandom_range(0, 7))
            0: return s;
            1: return s | 16'h7c00 | 16'($urandom_range(1, 1023));
            2: return s | 16'h7c00;
            3: return s | 16'h7bff;
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic logic [15:0] perturb(input logic [15:0] e);
        int mag;
        case ($urandom_range(0, 5))
            0, 1, 2: return e;
            3: begin
                mag = int'(e[14:0]) + $urandom_range(0, 8) - 4;
                if (mag < 0) mag = 0;
                if (mag > 'h7fff) mag = 'h7fff;
                return {e[15], 15'(mag)};
            end
            4: return e ^ 16'h8000;
            default: return gen_val();
        endcase
    endfunction

    initial begin
        logic [DW-1:0] ed, dd;
        logic [15:0]   vals[4];
        reset = 1; clear = 0; ulp_tol = 8'd0;
        exp_valid = 0; exp_data = '0; dut_valid = 0; dut_data = '0;
        saw_pulse = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("rst");
        @(negedge clk);
        reset = 0;

        // Basic stream, identical results
        vals = '{16'h3c00, 16'h4000, 16'hc200, 16'h7c00};
        for (int i = 0; i < 4; i++) cycle(1, rep4(vals[i]), 0, '0, 0);
        for (int i = 0; i < 4; i++) cycle(0, '0, 1, rep4(vals[i]), 0);
        idle(3);
        chk("t1_cmp", cmp_count, 4);
        chk("t1_err", err_count, 0);
        chk("t1_any", any_err, 0);
        chk("t1_pending", pending, 0);

        // NaN payload/sign and signed zero equality
        saw_pulse = 0;
        cycle(1, rep4(16'h7e00), 0, '0, 0);
        cycle(1, rep4(16'h0000), 0, '0, 0);
        cycle(0, '0, 1, rep4(16'hfe01), 0);
        cycle(0, '0, 1, rep4(16'h8000), 0);
        idle(3);
        chk("t2_nopulse", saw_pulse, 0);
        chk("t2_err", err_count, 0);

        // One ULP off with zero tolerance, then with tolerance 1
        do_clear();
        cycle(1, rep4(16'h3c00), 0, '0, 0);
        cycle(0, '0, 1, {16'h3c00, 16'h3c00, 16'h3c00, 16'h3c01}, 0);
        cycle(0, '0, 0, '0, 0);
        chk("t3_early", err_pulse, 0);
        cycle(0, '0, 0, '0, 0);
        chk("t3_pulse", err_pulse, 1);
        chk("t3_mask", err_lane_mask, 4'b0001);
        chk("t3_first", first_err_idx, 0);
        do_clear();
        ulp_tol = 8'd1;
        cycle(1, rep4(16'h3c00), 0, '0, 0);
        cycle(0, '0, 1, {16'h3c00, 16'h3c00, 16'h3c00, 16'h3c01}, 0);
        idle(3);
        chk("t3_tol_err", err_count, 0);
        chk("t3_tol_any", any_err, 0);
        ulp_tol = 8'd0;

        // Overflow, then simultaneous push/pop while full
        do_clear();
        for (int i = 0; i < 5; i++) cycle(1, rep4(16'(16'h3c00 + i)), 0, '0, 0);
        chk("t4_ovf", overflow, 1);
        chk("t4_pending", pending, 4);
        chk("t4_ready", exp_ready, 0);
        cycle(1, rep4(16'h4400), 1, rep4(16'h3c00), 0);
        chk("t4_pp_pending", pending, 4);
        chk("t4_pp_ovf", overflow, 1);
        idle(3);

        // Underflow with no bypass
        do_clear();
        cycle(1, rep4(16'h3c00), 1, rep4(16'h3c00), 0);
        chk("t5_unf", underflow, 1);
        chk("t5_pending", pending, 1);
        idle(3);
        chk("t5_cmp", cmp_count, 0);

        // Lane 2 corruption, then asynchronous reset mid-stream
        do_clear();
        ed = {16'h4500, 16'hbc00, 16'h3800, 16'h4000};
        dd = ed;
        dd[2*W +: W] = 16'h3805;
        cycle(1, ed, 0, '0, 0);
        cycle(0, '0, 1, dd, 0);
        idle(2);
        chk("t6_mask", err_lane_mask, 4'b0100);
        chk("t6_err", err_count, 1);
        cycle(1, ed, 0, '0, 0);
        cycle(1, ed, 1, dd, 0);
        #2;
        reset = 1;
        #1;
        check_reset_values("t6_arst");
        model_reset();
        @(negedge clk);
        reset = 0;
        idle(3);

        // Randomized traffic
        for (int blk = 0; blk < 4; blk++) begin
            do_clear();
            ulp_tol = 8'($urandom_range(0, 3));
            for (int c = 0; c < 150; c++) begin
                logic [DW-1:0] e_r, d_r;
                bit ev_r, dv_r;
                for (int l = 0; l < LANES; l++) e_r[l*W +: W] = gen_val();
                ev_r = ($urandom_range(0, 1) == 1);
                dv_r = ($urandom_range(0, 2) != 0);
                if (mq.size() > 0) begin
                    for (int l = 0; l < LANES; l++) d_r[l*W +: W] = perturb(mq[0][l*W +: W]);
                end else begin
                    for (int l = 0; l < LANES; l++) d_r[l*W +: W] = gen_val();
                end
                cycle(ev_r, e_r, dv_r, d_r, ($urandom_range(0, 99) == 0));
            end
            idle(3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
